// File: rtl/muldiv_if.sv
// Handshake and result bus between the execute-stage controller and the
// iterative multiply/divide unit.
interface muldiv_if #(
    parameter int WIDTH = 32
);
    logic             start;
    logic [1:0]       op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             abort;
    logic             mthi;
    logic             mtlo;
    logic [WIDTH-1:0] wdata;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;

    modport master (
        output start, op, a, b, abort, mthi, mtlo, wdata,
        input  busy, done, hi, lo
    );

    modport slave (
        input  start, op, a, b, abort, mthi, mtlo, wdata,
        output busy, done, hi, lo
    );
endinterface

// File: rtl/muldiv_seq.sv
// Iterative MULT/MULTU/DIV/DIVU unit owning HI/LO: one shared adder,
// WIDTH iterations of shift-add or restoring divide, then a sign fixup.
module muldiv_seq #(
    parameter int WIDTH = 32
) (
    input  logic     clk,
    input  logic     reset,
    muldiv_if.slave  bus
);
    localparam int CW = $clog2(WIDTH);

    typedef enum logic [1:0] {IDLE, CALC, FIXUP} state_t;

    state_t             r_state;
    state_t             w_stateNext;
    logic [CW-1:0]      r_cnt;
    logic [1:0]         r_op;
    logic               r_negQ;
    logic               r_negR;
    logic               r_divZero;
    logic [WIDTH-1:0]   r_aOrig;
    logic [WIDTH-1:0]   r_b;
    logic [WIDTH-1:0]   r_acc;
    logic [WIDTH-1:0]   r_work;
    logic [WIDTH-1:0]   r_hi;
    logic [WIDTH-1:0]   r_lo;
    logic               r_done;

    logic               w_load;
    logic               w_commit;
    logic               w_mtWrite;
    logic               w_isDiv;
    logic [WIDTH-1:0]   w_addA;
    logic [WIDTH-1:0]   w_addB;
    logic               w_cin;
    logic [WIDTH:0]     w_sum;
    logic               w_noBorrow;
    logic [2*WIDTH-1:0] w_prodNeg;
    logic [WIDTH-1:0]   w_hiRes;
    logic [WIDTH-1:0]   w_loRes;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) r_state <= IDLE;
        else       r_state <= w_stateNext;
    end

    // abort beats everything, including a start arriving in IDLE
    always_comb begin
        w_stateNext = r_state;
        w_load      = 1'b0;
        w_commit    = 1'b0;
        w_mtWrite   = 1'b0;
        case (r_state)
            IDLE: begin
                if (bus.start && !bus.abort) begin
                    w_stateNext = CALC;
                    w_load      = 1'b1;
                end
                w_mtWrite = !bus.start;
            end
            CALC: begin
                if (bus.abort)          w_stateNext = IDLE;
                else if (r_cnt == '0)   w_stateNext = FIXUP;
            end
            FIXUP: begin
                w_stateNext = IDLE;
                w_commit    = !bus.abort;
            end
            default: w_stateNext = IDLE;
        endcase
    end

    // Divide reuses the adder as a subtractor: A + ~B + 1
    assign w_isDiv    = r_op[1];
    assign w_addA     = w_isDiv ? {r_acc[WIDTH-2:0], r_work[WIDTH-1]} : r_acc;
    assign w_addB     = w_isDiv ? ~r_b : (r_work[0] ? r_b : '0);
    assign w_cin      = w_isDiv;
    assign w_sum      = {1'b0, w_addA} + {1'b0, w_addB} + {{WIDTH{1'b0}}, w_cin};
    assign w_noBorrow = r_acc[WIDTH-1] | w_sum[WIDTH];
    assign w_prodNeg  = -{r_acc, r_work};

    always_comb begin
        w_hiRes = r_acc;
        w_loRes = r_work;
        if (w_isDiv) begin
            if (r_divZero) begin
                w_hiRes = r_aOrig;
                w_loRes = '1;
            end else begin
                w_hiRes = r_negR ? -r_acc  : r_acc;
                w_loRes = r_negQ ? -r_work : r_work;
            end
        end else if (r_negQ) begin
            w_hiRes = w_prodNeg[2*WIDTH-1:WIDTH];
            w_loRes = w_prodNeg[WIDTH-1:0];
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_cnt     <= '0;
            r_op      <= '0;
            r_negQ    <= 1'b0;
            r_negR    <= 1'b0;
            r_divZero <= 1'b0;
            r_aOrig   <= '0;
            r_b       <= '0;
            r_acc     <= '0;
            r_work    <= '0;
            r_hi      <= '0;
            r_lo      <= '0;
            r_done    <= 1'b0;
        end else begin
            r_done <= w_commit;
            if (w_load) begin
                r_op      <= bus.op;
                r_negQ    <= bus.op[0] & (bus.a[WIDTH-1] ^ bus.b[WIDTH-1]);
                r_negR    <= bus.op[0] & bus.a[WIDTH-1];
                r_divZero <= bus.op[1] && (bus.b == '0);
                r_aOrig   <= bus.a;
                r_b       <= (bus.op[0] && bus.b[WIDTH-1]) ? -bus.b : bus.b;
                r_work    <= (bus.op[0] && bus.a[WIDTH-1]) ? -bus.a : bus.a;
                r_acc     <= '0;
                r_cnt     <= CW'(WIDTH-1);
            end else if (r_state == CALC && !bus.abort) begin
                if (w_isDiv) begin
                    r_acc  <= w_noBorrow ? w_sum[WIDTH-1:0] : w_addA;
                    r_work <= {r_work[WIDTH-2:0], w_noBorrow};
                end else begin
                    r_acc  <= w_sum[WIDTH:1];
                    r_work <= {w_sum[0], r_work[WIDTH-1:1]};
                end
                if (r_cnt != '0) r_cnt <= r_cnt - 1'b1;
            end
            if (w_commit) begin
                r_hi <= w_hiRes;
                r_lo <= w_loRes;
            end else if (w_mtWrite) begin
                if (bus.mthi) r_hi <= bus.wdata;
                if (bus.mtlo) r_lo <= bus.wdata;
            end
        end
    end

    assign bus.busy = (r_state != IDLE);
    assign bus.done = r_done;
    assign bus.hi   = r_hi;
    assign bus.lo   = r_lo;
endmodule

// File: tb/tb_muldiv_seq.sv
// Directed testbench for muldiv_seq: drives on the falling edge, samples on
// the falling edge, expected values are hand-computed constants.
module tb_muldiv_seq;
    localparam int W = 32;
    localparam logic [1:0] OP_MULTU = 2'b00, OP_MULT = 2'b01,
                           OP_DIVU  = 2'b10, OP_DIV  = 2'b11;

    logic clk;
    logic reset;
    int   testsRun;
    int   testsFailed;

    muldiv_if #(.WIDTH(W)) bus ();

    muldiv_seq #(.WIDTH(W)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic applyStimulus(input logic [1:0] op, input logic [W-1:0] a,
                                 input logic [W-1:0] b);
        @(negedge clk);
        bus.start = 1'b1;
        bus.op    = op;
        bus.a     = a;
        bus.b     = b;
        @(negedge clk);
        bus.start = 1'b0;
    endtask

    // Returns at the falling edge where done is seen; doneEdge counts the start edge as 1
    task automatic waitDone(output int doneEdge, output int busyCycles, output bit seen);
        seen       = 1'b0;
        doneEdge   = 1;
        busyCycles = bus.busy ? 1 : 0;
        for (int i = 0; i < 100 && !seen; i++) begin
            @(negedge clk);
            doneEdge++;
            if (bus.busy) busyCycles++;
            if (bus.done) seen = 1'b1;
        end
    endtask

    task automatic test_reset();
        repeat (2) @(negedge clk);
        testsRun++;
        if (bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.hi !== '0 || bus.lo !== '0) begin
            testsFailed++;
            $display("[TB] FAIL reset_state: busy=%b done=%b hi=%h lo=%h, want 0/0/0/0",
                     bus.busy, bus.done, bus.hi, bus.lo);
        end
        reset = 1'b0;
    endtask

    task automatic test_multu_latency();
        int de, bc;
        bit seen;
        applyStimulus(OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        waitDone(de, bc, seen);
        testsRun++;
        if (!seen || de !== 34) begin
            testsFailed++;
            $display("[TB] FAIL multu_done_edge: seen=%b edge=%0d, want edge 34", seen, de);
        end
        testsRun++;
        if (bc !== 33) begin
            testsFailed++;
            $display("[TB] FAIL multu_busy_cycles: got %0d, want 33", bc);
        end
        testsRun++;
        if (bus.hi !== 32'hFFFF_FFFE || bus.lo !== 32'h0000_0001) begin
            testsFailed++;
            $display("[TB] FAIL multu_result: hi=%h lo=%h, want fffffffe/00000001", bus.hi, bus.lo);
        end
        @(negedge clk);
        testsRun++;
        if (bus.done !== 1'b0) begin
            testsFailed++;
            $display("[TB] FAIL done_one_cycle: done=%b, want 0", bus.done);
        end
    endtask

    task automatic test_signed();
        int de, bc;
        bit seen;
        applyStimulus(OP_MULT, 32'hFFFF_FFFD, 32'd7);
        waitDone(de, bc, seen);
        testsRun++;
        if (!seen || bus.hi !== 32'hFFFF_FFFF || bus.lo !== 32'hFFFF_FFEB) begin
            testsFailed++;
            $display("[TB] FAIL mult_neg: seen=%b hi=%h lo=%h, want ffffffff/ffffffeb", seen, bus.hi, bus.lo);
        end
        applyStimulus(OP_DIV, 32'hFFFF_FFF9, 32'd2);
        waitDone(de, bc, seen);
        testsRun++;
        if (!seen || bus.hi !== 32'hFFFF_FFFF || bus.lo !== 32'hFFFF_FFFD) begin
            testsFailed++;
            $display("[TB] FAIL div_neg: seen=%b hi=%h lo=%h, want ffffffff/fffffffd", seen, bus.hi, bus.lo);
        end
    endtask

    task automatic test_div_corner();
        int de, bc;
        bit seen;
        applyStimulus(OP_DIVU, 32'd7, 32'd0);
        waitDone(de, bc, seen);
        testsRun++;
        if (!seen || de !== 34 || bus.hi !== 32'h0000_0007 || bus.lo !== 32'hFFFF_FFFF) begin
            testsFailed++;
            $display("[TB] FAIL div_by_zero: seen=%b edge=%0d hi=%h lo=%h, want 34/00000007/ffffffff",
                     seen, de, bus.hi, bus.lo);
        end
        applyStimulus(OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF);
        waitDone(de, bc, seen);
        testsRun++;
        if (!seen || bus.hi !== 32'h0000_0000 || bus.lo !== 32'h8000_0000) begin
            testsFailed++;
            $display("[TB] FAIL div_overflow: seen=%b hi=%h lo=%h, want 00000000/80000000", seen, bus.hi, bus.lo);
        end
    endtask

    task automatic test_abort();
        int de, bc;
        bit seen;
        bit doneSeen;
        doneSeen = 1'b0;
        applyStimulus(OP_DIVU, 32'd100, 32'd7);
        repeat (4) begin
            @(negedge clk);
            if (bus.done) doneSeen = 1'b1;
        end
        bus.start = 1'b1;
        bus.op    = OP_MULTU;
        bus.a     = 32'd5;
        bus.b     = 32'd5;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (4) begin
            @(negedge clk);
            if (bus.done) doneSeen = 1'b1;
        end
        bus.abort = 1'b1;
        @(negedge clk);
        bus.abort = 1'b0;
        testsRun++;
        if (bus.busy !== 1'b0) begin
            testsFailed++;
            $display("[TB] FAIL abort_busy: busy=%b, want 0", bus.busy);
        end
        repeat (3) begin
            @(negedge clk);
            if (bus.done) doneSeen = 1'b1;
        end
        testsRun++;
        if (doneSeen || bus.hi !== 32'h0 || bus.lo !== 32'h8000_0000) begin
            testsFailed++;
            $display("[TB] FAIL abort_keep: done_seen=%b hi=%h lo=%h, want 0/00000000/80000000",
                     doneSeen, bus.hi, bus.lo);
        end
        applyStimulus(OP_DIVU, 32'd100, 32'd7);
        waitDone(de, bc, seen);
        testsRun++;
        if (!seen || bus.hi !== 32'd2 || bus.lo !== 32'd14) begin
            testsFailed++;
            $display("[TB] FAIL divu_after_abort: seen=%b hi=%h lo=%h, want 2/14", seen, bus.hi, bus.lo);
        end
    endtask

    task automatic test_mt();
        int de, bc;
        bit seen;
        @(negedge clk);
        bus.mthi  = 1'b1;
        bus.wdata = 32'h1234;
        @(negedge clk);
        bus.mthi  = 1'b0;
        bus.mtlo  = 1'b1;
        bus.wdata = 32'h5678;
        @(negedge clk);
        bus.mtlo  = 1'b0;
        testsRun++;
        if (bus.hi !== 32'h1234 || bus.lo !== 32'h5678) begin
            testsFailed++;
            $display("[TB] FAIL mt_idle: hi=%h lo=%h, want 00001234/00005678", bus.hi, bus.lo);
        end
        applyStimulus(OP_MULTU, 32'd6, 32'd7);
        bus.mthi  = 1'b1;
        bus.wdata = 32'hDEAD_BEEF;
        @(negedge clk);
        bus.mthi  = 1'b0;
        testsRun++;
        if (bus.hi !== 32'h1234 || bus.busy !== 1'b1) begin
            testsFailed++;
            $display("[TB] FAIL mthi_busy: hi=%h busy=%b, want 00001234/1", bus.hi, bus.busy);
        end
        waitDone(de, bc, seen);
        testsRun++;
        if (!seen || bus.hi !== 32'd0 || bus.lo !== 32'd42) begin
            testsFailed++;
            $display("[TB] FAIL multu_6x7: seen=%b hi=%h lo=%h, want 0/42", seen, bus.hi, bus.lo);
        end
        @(negedge clk);
        bus.start = 1'b1;
        bus.op    = OP_MULTU;
        bus.a     = 32'd3;
        bus.b     = 32'd5;
        bus.mtlo  = 1'b1;
        bus.wdata = 32'hFFFF;
        @(negedge clk);
        bus.start = 1'b0;
        bus.mtlo  = 1'b0;
        testsRun++;
        if (bus.busy !== 1'b1 || bus.lo !== 32'd42) begin
            testsFailed++;
            $display("[TB] FAIL mtlo_with_start: busy=%b lo=%h, want 1/42", bus.busy, bus.lo);
        end
        waitDone(de, bc, seen);
        testsRun++;
        if (!seen || bus.hi !== 32'd0 || bus.lo !== 32'd15) begin
            testsFailed++;
            $display("[TB] FAIL multu_3x5: seen=%b hi=%h lo=%h, want 0/15", seen, bus.hi, bus.lo);
        end
    endtask

    task automatic test_async_reset();
        int de, bc;
        bit seen;
        applyStimulus(OP_MULTU, 32'd9, 32'd9);
        repeat (5) @(negedge clk);
        #2 reset = 1'b1;
        #1;
        testsRun++;
        if (bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.hi !== '0 || bus.lo !== '0) begin
            testsFailed++;
            $display("[TB] FAIL async_reset: busy=%b done=%b hi=%h lo=%h, want 0/0/0/0",
                     bus.busy, bus.done, bus.hi, bus.lo);
        end
        @(negedge clk);
        reset = 1'b0;
        applyStimulus(OP_MULTU, 32'd6, 32'd7);
        waitDone(de, bc, seen);
        testsRun++;
        if (!seen || bus.hi !== 32'd0 || bus.lo !== 32'd42) begin
            testsFailed++;
            $display("[TB] FAIL after_reset_multu: seen=%b hi=%h lo=%h, want 0/42", seen, bus.hi, bus.lo);
        end
    endtask

    initial begin
        testsRun    = 0;
        testsFailed = 0;
        reset       = 1'b1;
        bus.start   = 1'b0;
        bus.op      = 2'b00;
        bus.a       = '0;
        bus.b       = '0;
        bus.abort   = 1'b0;
        bus.mthi    = 1'b0;
        bus.mtlo    = 1'b0;
        bus.wdata   = '0;
        test_reset();
        test_multu_latency();
        test_signed();
        test_div_corner();
        test_abort();
        test_mt();
        test_async_reset();
        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end
endmodule
